// File: rtl/demux_pkg.sv
// Shared constants and select-decoding helper for the demux block.
package demux_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH   = 4;
  localparam int unsigned DEFAULT_SEL_WIDTH    = 3;
  localparam int unsigned DEFAULT_OUTPUT_WIDTH = 5;

  // Widest lane count the helper can describe; decoders slice down to their own width.
  localparam int unsigned MAX_LANES = 64;

  typedef struct packed {
    logic                 oor;
    logic [MAX_LANES-1:0] hot;
  } onehot_t;

  // One-hot of sel over n lanes; oor set (and hot all zero) when sel >= n.
  function automatic onehot_t onehot(input logic [31:0] sel, input int unsigned n);
    onehot_t r;
    r = '0;
    if (sel < n) begin
      r.hot[sel[5:0]] = 1'b1;
    end else begin
      r.oor = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_decode.sv
// Combinational select decoder: one-hot lane vector plus out-of-range flag.
module demux_decode
  import demux_pkg::*;
#(
  parameter int unsigned SEL_WIDTH    = DEFAULT_SEL_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
  input  logic [SEL_WIDTH-1:0]    sel,
  output logic [OUTPUT_WIDTH-1:0] lane_c,
  output logic                    err_c
);

  onehot_t dec;

  // Full-width compare of sel; no truncation before the range test.
  always_comb begin
    dec    = onehot(32'(sel), OUTPUT_WIDTH);
    lane_c = dec.hot[OUTPUT_WIDTH-1:0];
    err_c  = dec.oor;
  end

  // Helper bits above this decoder's lane count are always zero here.
  if (OUTPUT_WIDTH < MAX_LANES) begin : g_spare
    logic unused_hot;
    assign unused_hot = ^dec.hot[MAX_LANES-1:OUTPUT_WIDTH];
  end

endmodule

// File: rtl/demux.sv
// Registered 1-to-N demultiplexer with one-hot lane flag and out-of-range error.
module demux
  import demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned SEL_WIDTH    = DEFAULT_SEL_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [SEL_WIDTH-1:0]    sel_i,
  output logic [DATA_WIDTH-1:0]   data_o [OUTPUT_WIDTH-1:0],
  output logic [OUTPUT_WIDTH-1:0] lane_o,
  output logic                    err_o
);

  // Reject lane counts the select cannot address or the helper cannot describe.
  if (OUTPUT_WIDTH < 1 || OUTPUT_WIDTH > (64'd1 << SEL_WIDTH) || OUTPUT_WIDTH > MAX_LANES)
  begin : g_bad_cfg
    $error("demux: OUTPUT_WIDTH must be in 1..2**SEL_WIDTH");
  end

  logic [OUTPUT_WIDTH-1:0] lane_c;
  logic                    err_c;

  demux_decode #(
    .SEL_WIDTH    (SEL_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_decode (
    .sel    (sel_i),
    .lane_c (lane_c),
    .err_c  (err_c)
  );

  // Register lanes: selected lane loads data, all others clear on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(OUTPUT_WIDTH); i++) begin
        data_o[i] <= '0;
      end
      lane_o <= '0;
      err_o  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(OUTPUT_WIDTH); i++) begin
        data_o[i] <= lane_c[i] ? data_i : '0;
      end
      lane_o <= lane_c;
      err_o  <= err_c;
    end
  end

endmodule

// File: tb/tb_demux.sv
// Randomized self-checking bench for demux against a behavioural lane model.
module tb_demux;

  localparam int DW = 4;
  localparam int SW = 3;
  localparam int NL = 5;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [SW-1:0] sel_i = '0;
  logic [DW-1:0] data_o [NL-1:0];
  logic [NL-1:0] lane_o;
  logic          err_o;

  int checks = 0;
  int failures = 0;

  demux #(
    .DATA_WIDTH   (DW),
    .SEL_WIDTH    (SW),
    .OUTPUT_WIDTH (NL)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .data_i (data_i),
    .sel_i  (sel_i),
    .data_o (data_o),
    .lane_o (lane_o),
    .err_o  (err_o)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs after sampling (d, s): data lands only on lane s if it exists.
  task automatic check_model(input string tag, input int d, input int s);
    int exp_lane;
    exp_lane = (s < NL) ? (1 << s) : 0;
    for (int i = 0; i < NL; i++) begin
      check($sformatf("%s.data%0d", tag, i), 32'(data_o[i]), (i == s) ? 32'(d) : 32'd0);
    end
    check({tag, ".lane"}, 32'(lane_o), 32'(exp_lane));
    check({tag, ".err"}, 32'(err_o), (s >= NL) ? 32'd1 : 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < NL; i++) begin
      check($sformatf("%s.data%0d", tag, i), 32'(data_o[i]), 32'd0);
    end
    check({tag, ".lane"}, 32'(lane_o), 32'd0);
    check({tag, ".err"}, 32'(err_o), 32'd0);
  endtask

  // Drive inputs mid-cycle, then check one cycle of latency just after the edge.
  task automatic step(input string tag, input int d, input int s);
    @(negedge clk);
    data_i = DW'(d);
    sel_i  = SW'(s);
    @(posedge clk);
    #1;
    check_model(tag, d, s);
  endtask

  initial begin
    // Reset with no clock running.
    data_i = 4'hA;
    sel_i  = 3'd2;
    #1 rst = 1'b1;
    #2 check_cleared("rst_noclk");
    #2 rst = 1'b0;
    clk_en = 1'b1;

    // Reset release: first edge loads normally.
    step("post_rst", 4'hA, 2);

    // Sweep over valid lanes.
    for (int s = 0; s < NL; s++) step($sformatf("sweep%0d", s), 4'hA, s);

    // Out of range, then recover.
    step("oor5", 4'h6, 5);
    step("oor7", 4'h9, 7);
    step("recover2", 4'hC, 2);

    // Zero data on a valid lane still flags the lane.
    step("zero3", 0, 3);

    // Mid-stream reset between edges.
    step("pre_rst", 4'hF, 1);
    #1 rst = 1'b1;
    #1 check_cleared("mid_rst");
    #1 rst = 1'b0;
    #1 check_cleared("mid_rst_rel");
    step("reload1", 4'hF, 1);

    // Randomized routing, including out-of-range selects.
    for (int n = 0; n < 200; n++) begin
      step("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the width in bits of the input word and of each output lane.
REQ-002 Parameter SEL_WIDTH, default 3, SHALL set the width in bits of the select input.
REQ-003 Parameter OUTPUT_WIDTH, default 5, SHALL set the number of output lanes; legal only if 1 <= OUTPUT_WIDTH <= 2**SEL_WIDTH.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 data_i  input  DATA_WIDTH  SHALL be the word to route.
REQ-007 sel_i  input  SEL_WIDTH  SHALL be the binary index of the destination lane.
REQ-008 data_o  output  unpacked array [OUTPUT_WIDTH-1:0] of DATA_WIDTH  SHALL carry the registered output lanes.
REQ-009 lane_o  output  OUTPUT_WIDTH  SHALL be a registered one-hot flag marking the active lane; all zeros when no lane is active.
REQ-010 err_o  output  1  SHALL be a registered flag, high when the sampled sel_i was out of range.

Function
REQ-011 At each rising clk_i edge, with sel_i < OUTPUT_WIDTH, data_o[sel_i] SHALL load data_i.
REQ-012 At that same edge, every other lane SHALL load all zeros.
REQ-013 Latency SHALL be one cycle: outputs reflect the data_i/sel_i sampled at the previous rising edge; no combinational path from inputs to outputs.
REQ-014 lane_o SHALL equal 1 << sel_i for in-range select, registered alongside data_o.
REQ-015 When sel_i >= OUTPUT_WIDTH (e.g. 5..7 with defaults), at the next edge all data_o lanes SHALL be zero, lane_o SHALL be zero, and err_o SHALL be 1.
REQ-016 err_o SHALL be 0 at any edge that samples an in-range sel_i; it is re-evaluated every cycle, not sticky.
REQ-017 Changing sel_i every cycle SHALL move the data cleanly: the previous lane clears on the same edge the new lane loads, so at most one lane is ever non-zero.
REQ-018 A data_i value of all zeros on a valid lane SHALL still set lane_o and clear err_o, so "zero data" and "no lane" are distinguishable only via lane_o.
REQ-019 Select decoding SHALL compare the full SEL_WIDTH bits, with no truncation or wrap-around of sel_i.

Reset
REQ-020 While rst_i is high, all data_o lanes, lane_o and err_o SHALL be 0, immediately and without waiting for a clock edge.
REQ-021 Reset asserted mid-operation SHALL clear the outputs asynchronously.
REQ-022 After rst_i deasserts, the first rising edge SHALL load the outputs normally from the inputs present at that edge.

Structure
REQ-023 A shared package demux_pkg SHALL hold the default parameter constants and a helper function returning one-hot(sel, n) with an out-of-range indication.
REQ-024 A combinational sub-module demux_decode SHALL convert sel_i into a one-hot OUTPUT_WIDTH vector plus an out-of-range flag; demux registers its results.
REQ-025 An elaboration-time check SHALL fail if OUTPUT_WIDTH > 2**SEL_WIDTH or OUTPUT_WIDTH < 1.

Verification
REQ-026 Reset: assert rst_i with no clock running -> data_o all 4'h0, lane_o=5'b00000, err_o=0.
REQ-027 Sweep: data_i=4'b1010, sel_i=0,1,2,3,4, one per cycle -> one cycle later data_o[sel]=4'hA, other lanes 0, lane_o=00001, 00010, 00100, 01000, 10000 in turn.
REQ-028 Out of range: sel_i=5, then 7 -> data_o all 0, lane_o=0, err_o=1; then sel_i=2 -> err_o=0, data_o[2]=data_i.
REQ-029 Zero data: data_i=0, sel_i=3 -> data_o all 0, lane_o=01000, err_o=0.
REQ-030 Mid-stream reset: sel_i=1, data_i=4'hF, pulse rst_i between clock edges -> outputs clear immediately; the first edge after release reloads data_o[1]=4'hF.
